// File: rtl/key_entry_pkg.sv
// rtl/key_entry_pkg.sv - shared types, key indices and BCD step helper for key_entry
package key_entry_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EDIT = 1'b1
    } state_e;

    localparam int KEY_INC    = 0;
    localparam int KEY_NEXT   = 1;
    localparam int KEY_COMMIT = 2;
    localparam int NUM_KEYS   = 3;

    // Wraps 9->0 upward and 0->9 downward; out-of-range inputs fold back to 0 going up.
    function automatic logic [3:0] bcd_step(input logic [3:0] digit, input logic dir);
        logic [3:0] res;
        if (!dir) begin
            res = (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
        end else begin
            res = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/key_entry_if.sv
// rtl/key_entry_if.sv - button inputs and BCD/display outputs of key_entry
interface key_entry_if;
    logic [2:0]  key_n;
    logic        dir;
    logic [3:0]  digit3;
    logic [3:0]  digit2;
    logic [3:0]  digit1;
    logic [3:0]  digit0;
    logic [1:0]  sel;
    logic [3:0]  blank_mask;
    logic        editing;
    logic        load_valid;
    logic [15:0] load_value;

    modport master (
        output key_n, dir,
        input  digit3, digit2, digit1, digit0, sel, blank_mask,
               editing, load_valid, load_value
    );

    modport slave (
        input  key_n, dir,
        output digit3, digit2, digit1, digit0, sel, blank_mask,
               editing, load_valid, load_value
    );
endinterface

// File: rtl/key_entry_debounce.sv
// rtl/key_entry_debounce.sv - one button: 2-flop sync, level debounce, single press pulse
module key_debounce #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= key_n_i;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            // Falling debounced level only; releases are silent.
            press_q      <= level_prev_q & ~level_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/key_entry.sv
// rtl/key_entry.sv - digit-by-digit BCD entry with blink mask and one-cycle commit strobe
module key_entry
    import key_entry_pkg::*;
#(
    parameter int DB_CYCLES    = 500_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    key_entry_if.slave  bus
);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    logic [NUM_KEYS-1:0] press;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (bus.key_n[KEY_INC]),
        .press_o (press[KEY_INC])
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (bus.key_n[KEY_NEXT]),
        .press_o (press[KEY_NEXT])
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_commit (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (bus.key_n[KEY_COMMIT]),
        .press_o (press[KEY_COMMIT])
    );

    state_e        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    digit_q [4];
    logic [3:0]    digit_d [4];
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    blank_mask_q, blank_mask_d;
    logic          editing_q;
    logic          load_valid_q, load_valid_d;
    logic [15:0]   load_value_q, load_value_d;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        digit_d      = digit_q;
        blink_cnt_d  = blink_cnt_q;
        phase_d      = phase_q;
        load_valid_d = 1'b0;
        load_value_d = load_value_q;

        case (state_q)
            IDLE: begin
                if (press[KEY_NEXT]) begin
                    state_d     = EDIT;
                    sel_d       = 2'd3;
                    blink_cnt_d = '0;
                    phase_d     = 1'b0;
                end
            end
            EDIT: begin
                if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
                    blink_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
                // Only the highest-priority event of a cycle takes effect.
                if (press[KEY_COMMIT]) begin
                    load_value_d = {digit_q[3], digit_q[2], digit_q[1], digit_q[0]};
                    load_valid_d = 1'b1;
                    state_d      = IDLE;
                    sel_d        = 2'd3;
                end else if (press[KEY_NEXT]) begin
                    sel_d = (sel_q == 2'd0) ? 2'd3 : sel_q - 2'd1;
                end else if (press[KEY_INC]) begin
                    digit_d[sel_q] = bcd_step(digit_q[sel_q], bus.dir);
                end
            end
            default: state_d = IDLE;
        endcase

        blank_mask_d = (state_d == EDIT && phase_d) ? (4'b0001 << sel_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 2'd3;
            digit_q      <= '{default: 4'd0};
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            blank_mask_q <= 4'b0000;
            editing_q    <= 1'b0;
            load_valid_q <= 1'b0;
            load_value_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            digit_q      <= digit_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            blank_mask_q <= blank_mask_d;
            editing_q    <= (state_d == EDIT);
            load_valid_q <= load_valid_d;
            load_value_q <= load_value_d;
        end
    end

    assign bus.digit3     = digit_q[3];
    assign bus.digit2     = digit_q[2];
    assign bus.digit1     = digit_q[1];
    assign bus.digit0     = digit_q[0];
    assign bus.sel        = sel_q;
    assign bus.blank_mask = blank_mask_q;
    assign bus.editing    = editing_q;
    assign bus.load_valid = load_valid_q;
    assign bus.load_value = load_value_q;

endmodule

// File: doc/key_entry.md
Name: key_entry

Overview:
- User-input companion to the 4-digit BCD counter/7-seg display block. It turns raw push-button presses into a 4-digit BCD value that is edited digit by digit and then committed.
- Output feeds the counter's preload path and the display (digits plus blank mask for the digit being edited).
- Sits at board top level between KEY[3:1] and the counter.

Parameters:
- DB_CYCLES, 500_000, consecutive stable synced samples needed to accept a key level change (10 ms at 50 MHz).
- BLINK_CYCLES, 12_500_000, cycles per blink phase (250 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous active-low reset; top level drives it from KEY[0].
- key_n  in  3  raw active-low buttons: [0]=inc (KEY[1]), [1]=next (KEY[2]), [2]=commit (KEY[3]).
- dir  in  1  0 = inc adds 1, 1 = inc subtracts 1 (from sw[0]).
- digit3..digit0  out  4 each  BCD digits; digit3 is most significant.
- sel  out  2  index of the digit being edited.
- blank_mask  out  4  one-hot bit for the digit the display should blank.
- editing  out  1  high while in EDIT.
- load_valid  out  1  one-cycle commit strobe.
- load_value  out  16  {digit3,digit2,digit1,digit0}; valid when load_valid is high.

Behaviour:
- Reset, sampled on the clk edge with rst_n=0:
  - state IDLE, all digits 0, sel 3.
  - blank_mask 0, editing 0, load_valid 0, load_value 0.
  - sync flops 1, debounced levels 1 (released), debounce and blink counters 0.
  - Reset wins over every other event and may arrive at any time, including mid-edit.
- Input path, per key:
  - 2-flop synchronizer.
  - Debounce counter increments while the synced level differs from the debounced level. It clears to 0 on any cycle they match.
  - When the counter reaches DB_CYCLES-1 with the mismatch still present, the debounced level takes the synced level and the counter clears.
- Press event:
  - One-cycle pulse, registered in the same cycle the debounced level goes 1->0.
  - It is high exactly DB_CYCLES+2 cycles after the raw key is first sampled low, provided the key stays low throughout.
  - Release generates no event. A key held low generates exactly one event.
- FSM states: IDLE, EDIT.
- IDLE:
  - next event -> EDIT with sel=3.
  - inc and commit events are ignored.
- EDIT:
  - Event priority within one cycle: commit > next > inc. Lower-priority events in that cycle are dropped.
  - commit: load_value <= digits, load_valid=1 for exactly one cycle, state -> IDLE, sel -> 3.
  - next: sel 3->2->1->0->3 (wraps from 0 back to 3).
  - inc with dir=0: digit[sel] = 9 ? 0 : +1.
  - inc with dir=1: digit[sel] = 0 ? 9 : -1.
  - No carry or borrow into neighbouring digits.
- Digits:
  - Always valid BCD (0-9).
  - Retained across IDLE and after commit, so the next edit starts from the last value.
- Blink:
  - Counter runs only in EDIT. A phase flag toggles every BLINK_CYCLES.
  - blank_mask = (phase ? one-hot(sel) : 0).
  - On entry to EDIT: counter = 0 and phase = 0.
  - In IDLE: blank_mask = 0.
- Outputs are registered. editing reflects state with no combinational path from key_n.

Decomposition:
- Package key_entry_pkg:
  - state enum (IDLE, EDIT).
  - key index constants KEY_INC=0, KEY_NEXT=1, KEY_COMMIT=2.
  - function bcd_step(digit, dir) returning the wrapped BCD digit.
- Sub-module key_debounce: one key's synchronizer, debounce counter and press pulse, parameter DB_CYCLES. Instantiated 3 times.

Test Plan (DB_CYCLES=4, BLINK_CYCLES=8):
1. Reset: rst_n=0 for 2 cycles with keys idle -> digits 0000, sel=3, editing=0, blank_mask=0, load_valid=0.
2. Bounce on inc while in EDIT:
   - key_n[0] low 3 cycles then high, repeated 5 times -> no event, digit3 stays 0.
   - Then held low 20 cycles -> exactly one increment, pulse at cycle 6 after first low sample.
3. Entry:
   - Key sequence: next, inc x2, next, next, next, inc x9, commit.
   - Response: load_valid high for 1 cycle, load_value=16'h2009, editing returns to 0, digits hold 2,0,0,9.
4. Wrap:
   - dir=0, digit at 9 + inc -> 0.
   - dir=1, digit at 0 + inc -> 9.
   - sel=0 + next -> sel=3.
   - inc in IDLE -> no change.
5. Priority: commit and inc events in the same cycle -> load_valid=1, digit unchanged. Also check next and inc together -> sel moves, digit unchanged.
6. Blink and mid-edit reset:
   - In EDIT with sel=1 -> blank_mask alternates 0000/0010 every 8 cycles.
   - Then assert rst_n=0 -> next cycle digits 0000, IDLE, blank_mask 0, no load_valid.
